// File: rtl/avs_regfile.sv
// avs_regfile: Avalon-MM slave register file with wait states, read-only core-written registers and IEN/ISR interrupt logic
module avs_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int WAIT_STATES = 0,
  parameter logic [2**ADDR_W-1:0] RO_MASK = '0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [ADDR_W-1:0]              avs_s0_address,
  input  logic                           avs_s0_read,
  input  logic                           avs_s0_write,
  input  logic [DATA_W-1:0]              avs_s0_writedata,
  input  logic [DATA_W/8-1:0]            avs_s0_byteenable,
  output logic [DATA_W-1:0]              avs_s0_readdata,
  output logic                           avs_s0_waitrequest,
  input  logic                           hw_wr,
  input  logic [ADDR_W-1:0]              hw_addr,
  input  logic [DATA_W-1:0]              hw_wdata,
  input  logic [DATA_W-1:0]              hw_irq_set,
  output logic [(2**ADDR_W)*DATA_W-1:0]  reg_out,
  output logic                           irq
);
  localparam int DEPTH = 2**ADDR_W;
  localparam logic [DEPTH-1:0] RO = {RO_MASK[DEPTH-1:2], 2'b00};
  localparam logic [3:0] WS_M1 = 4'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);
  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;
  state_t state, state_d;
  logic [3:0] cnt, cnt_d;
  logic [DEPTH-1:0][DATA_W-1:0] regs, regs_d;
  logic [DATA_W-1:0] be_mask;
  logic req, bus_we, rd_hit;
  assign req = avs_s0_read | avs_s0_write;
  assign bus_we = (state == ACK) && avs_s0_write;
  assign rd_hit = (state_d == ACK) && avs_s0_read && !avs_s0_write;
  assign avs_s0_waitrequest = state != ACK;
  assign reg_out = regs;
  for (genvar i = 0; i < DATA_W/8; i++) begin : g_be
    assign be_mask[i*8 +: 8] = {8{avs_s0_byteenable[i]}};
  end
  always_comb begin
    state_d = state;
    cnt_d = cnt;
    case (state)
      IDLE: if (req) begin
        state_d = (WAIT_STATES == 0) ? ACK : WAIT;
        cnt_d = WS_M1;
      end
      WAIT: if (!req) state_d = IDLE;
            else if (cnt == 4'd0) state_d = ACK;
            else cnt_d = cnt - 4'd1;
      default: state_d = IDLE;
    endcase
  end
  // ISR clears on written ones; hw set pulses are applied last so they win
  always_comb begin
    regs_d = regs;
    if (bus_we && !RO[avs_s0_address])
      regs_d[avs_s0_address] = (avs_s0_address == ADDR_W'(1))
        ? regs[1] & ~(avs_s0_writedata & be_mask)
        : (regs[avs_s0_address] & ~be_mask) | (avs_s0_writedata & be_mask);
    if (hw_wr && RO[hw_addr]) regs_d[hw_addr] = hw_wdata;
    regs_d[1] = regs_d[1] | hw_irq_set;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      avs_s0_readdata <= '0;
      irq <= 1'b0;
      regs <= '0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      avs_s0_readdata <= rd_hit ? regs[avs_s0_address] : '0;
      irq <= |(regs[1] & regs[0]);
      regs <= regs_d;
    end
  end
endmodule

// File: tb/tb_avs_regfile.sv
// tb_avs_regfile: scoreboard bench for avs_regfile with a zero-wait-state and a three-wait-state instance
module tb_avs_regfile;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  logic rd[2], wr[2], hw_wr[2], wait_r[2], irq[2];
  logic [3:0] addr[2], be[2], hw_addr[2];
  logic [31:0] wdata[2], rdata[2], hw_wdata[2], hw_irq_set[2];
  logic [511:0] rout[2];
  logic [31:0] q0[$], q1[$];
  logic [31:0] mon_e;
  int n_chk = 0, n_fail = 0;
  int w;

  avs_regfile #(.WAIT_STATES(0), .RO_MASK(16'h0040)) dut0 (
    .clk(clk), .reset(reset), .avs_s0_address(addr[0]), .avs_s0_read(rd[0]), .avs_s0_write(wr[0]),
    .avs_s0_writedata(wdata[0]), .avs_s0_byteenable(be[0]), .avs_s0_readdata(rdata[0]),
    .avs_s0_waitrequest(wait_r[0]), .hw_wr(hw_wr[0]), .hw_addr(hw_addr[0]), .hw_wdata(hw_wdata[0]),
    .hw_irq_set(hw_irq_set[0]), .reg_out(rout[0]), .irq(irq[0]));
  avs_regfile #(.WAIT_STATES(3)) dut3 (
    .clk(clk), .reset(reset), .avs_s0_address(addr[1]), .avs_s0_read(rd[1]), .avs_s0_write(wr[1]),
    .avs_s0_writedata(wdata[1]), .avs_s0_byteenable(be[1]), .avs_s0_readdata(rdata[1]),
    .avs_s0_waitrequest(wait_r[1]), .hw_wr(hw_wr[1]), .hw_addr(hw_addr[1]), .hw_wdata(hw_wdata[1]),
    .hw_irq_set(hw_irq_set[1]), .reg_out(rout[1]), .irq(irq[1]));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rg(input int d, input int k);
    return rout[d][k*32 +: 32];
  endfunction

  // monitor: every read ACK pops the scoreboard, every other cycle readdata must be 0
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!wait_r[d] && rd[d]) begin
        if ((d == 0 ? q0.size() : q1.size()) == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_ack dut%0d: got readdata %0h expected no ack", d, rdata[d]);
        end else begin
          if (d == 0) mon_e = q0.pop_front();
          else mon_e = q1.pop_front();
          check($sformatf("readdata_dut%0d", d), rdata[d], mon_e);
        end
      end else check($sformatf("readdata_zero_dut%0d", d), rdata[d], 0);
    end
  end

  task automatic xfer(input int d, input bit r, input bit wv, input logic [3:0] a, input logic [31:0] dat,
                      input logic [3:0] b, input logic [31:0] exp, input bit hw_en, input logic [31:0] hw_dat,
                      output int waits);
    bit acked = 0;
    if (r && d == 0) q0.push_back(exp);
    if (r && d == 1) q1.push_back(exp);
    rd[d] = r; wr[d] = wv; addr[d] = a; wdata[d] = dat; be[d] = b;
    waits = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!wait_r[d]) begin
        acked = 1;
        break;
      end
      waits++;
    end
    if (acked && hw_en) begin
      hw_wr[d] = 1; hw_addr[d] = a; hw_wdata[d] = hw_dat;
    end
    @(posedge clk); #1;
    rd[d] = 0; wr[d] = 0; hw_wr[d] = 0;
    if (!acked) begin
      n_chk++;
      n_fail++;
      $display("FAIL ack_timeout dut%0d: got no ack expected ack within 40 cycles", d);
    end
  endtask

  task automatic hw(input int d, input logic [3:0] a, input logic [31:0] dat);
    hw_wr[d] = 1; hw_addr[d] = a; hw_wdata[d] = dat;
    @(posedge clk); #1;
    hw_wr[d] = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1);
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      rd[d] = 0; wr[d] = 0; hw_wr[d] = 0; addr[d] = 0; be[d] = 0; hw_addr[d] = 0;
      wdata[d] = 0; hw_wdata[d] = 0; hw_irq_set[d] = 0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("reset_waitrequest", wait_r[d], 1);
      check("reset_irq", irq[d], 0);
      check("reset_regs_zero", rout[d] == '0, 1);
    end
    @(posedge clk); #1;
    reset = 0;
    // zero wait states: basic write/read, byte lanes
    xfer(0, 0, 1, 5, 32'hDEADBEEF, 4'hF, 0, 0, 0, w);
    check("ws0_write_waits", w, 1);
    xfer(0, 1, 0, 5, 0, 0, 32'hDEADBEEF, 0, 0, w);
    check("ws0_read_waits", w, 1);
    check("reg_out5", rg(0, 5), 32'hDEADBEEF);
    xfer(0, 0, 1, 3, 32'hFFFFFFFF, 4'h5, 0, 0, 0, w);
    xfer(0, 1, 0, 3, 0, 0, 32'h00FF00FF, 0, 0, w);
    // read-only register 6
    xfer(0, 0, 1, 6, 32'h1234, 4'hF, 0, 0, 0, w);
    xfer(0, 1, 0, 6, 0, 0, 32'h0, 0, 0, w);
    hw(0, 6, 32'hABCD);
    xfer(0, 1, 0, 6, 0, 0, 32'hABCD, 0, 0, w);
    hw(0, 5, 32'h5555);
    xfer(0, 1, 0, 5, 0, 0, 32'hDEADBEEF, 0, 0, w);
    xfer(0, 1, 0, 6, 0, 0, 32'hABCD, 1, 32'h7777, w);
    xfer(0, 1, 0, 6, 0, 0, 32'h7777, 0, 0, w);
    // simultaneous read and write acts as a write
    xfer(0, 1, 1, 7, 32'h11, 4'hF, 32'h0, 0, 0, w);
    xfer(0, 1, 0, 7, 0, 0, 32'h11, 0, 0, w);
    // interrupts
    xfer(0, 0, 1, 0, 32'h1, 4'hF, 0, 0, 0, w);
    hw_irq_set[0] = 32'h1;
    @(posedge clk); #1;
    hw_irq_set[0] = 0;
    check("isr_set", rg(0, 1), 32'h1);
    check("irq_latency", irq[0], 0);
    @(posedge clk); #1;
    check("irq_rise", irq[0], 1);
    hw_irq_set[0] = 32'h1;
    xfer(0, 0, 1, 1, 32'h1, 4'hF, 0, 0, 0, w);
    hw_irq_set[0] = 0;
    check("isr_set_wins", rg(0, 1), 32'h1);
    xfer(0, 0, 1, 1, 32'h1, 4'hF, 0, 0, 0, w);
    check("isr_clear", rg(0, 1), 32'h0);
    check("irq_hold", irq[0], 1);
    @(posedge clk); #1;
    check("irq_fall", irq[0], 0);
    hw_irq_set[0] = 32'h10;
    @(posedge clk); #1;
    hw_irq_set[0] = 0;
    repeat (2) @(posedge clk);
    #1;
    check("irq_masked", irq[0], 0);
    xfer(0, 1, 0, 1, 0, 0, 32'h10, 0, 0, w);
    xfer(0, 0, 1, 1, 32'hFFFFFFFF, 4'h0, 0, 0, 0, w);
    check("isr_no_lane", rg(0, 1), 32'h10);
    xfer(0, 0, 1, 1, 32'hFFFFFFFF, 4'hF, 0, 0, 0, w);
    check("isr_clear_all", rg(0, 1), 32'h0);
    // three wait states
    xfer(1, 0, 1, 2, 32'hCAFE, 4'hF, 0, 0, 0, w);
    check("ws3_write_waits", w, 4);
    xfer(1, 1, 0, 2, 0, 0, 32'hCAFE, 0, 0, w);
    check("ws3_read_waits", w, 4);
    rd[1] = 1; addr[1] = 2;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rd[1] = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("abort_waitrequest", wait_r[1], 1);
    end
    @(posedge clk); #1;
    xfer(1, 1, 0, 2, 0, 0, 32'hCAFE, 0, 0, w);
    check("after_abort_waits", w, 4);
    // reset during a write in WAIT, with irq active beforehand
    xfer(1, 0, 1, 0, 32'h1, 4'hF, 0, 0, 0, w);
    hw_irq_set[1] = 32'h1;
    @(posedge clk); #1;
    hw_irq_set[1] = 0;
    @(posedge clk); #1;
    check("ws3_irq_rise", irq[1], 1);
    rd[1] = 0; wr[1] = 1; addr[1] = 2; wdata[1] = 32'h55; be[1] = 4'hF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst_waitrequest", wait_r[1], 1);
      check("rst_irq", irq[1], 0);
      check("rst_reg2", rg(1, 2), 32'h0);
    end
    @(posedge clk); #1;
    reset = 0;
    xfer(1, 0, 1, 2, 32'h55, 4'hF, 0, 0, 0, w);
    check("restart_waits", w, 4);
    check("restart_reg2", rg(1, 2), 32'h55);
    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
